// File: rtl/axb_xbar_pkg.sv
// axb_xbar_pkg: shared types, default constants and select-width helper for the AXB crossbar
// Contents: slave FSM state enum, DEF_RDATA/TMO_CYC defaults, selw() index-width function
package axb_xbar_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RSP} slv_st_e;

    localparam logic [7:0] DEF_RDATA_C = 8'hAC;
    localparam int         TMO_CYC_C   = 256;

    // Index width for n items, never below one bit
    function automatic int selw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axb_xbar_rr_if.sv
// axb_xbar_rr_if: all master-side (m_*) and slave-side (s_*) crossbar signals
// Modports: master = bus masters plus slave ports (drive requests / responses into the crossbar),
//           slave  = the crossbar itself
interface axb_xbar_rr_if #(
    parameter int MSTN = 4,
    parameter int SLVN = 8,
    parameter int AW   = 16,
    parameter int DW   = 8
);
    logic [MSTN-1:0]    m_req_vld, m_req_rdy;
    logic [MSTN*AW-1:0] m_req_addr;
    logic [MSTN*DW-1:0] m_req_data;
    logic [MSTN-1:0]    m_rsp_vld, m_rsp_rdy, m_rsp_err;
    logic [MSTN*DW-1:0] m_rsp_data;
    logic [SLVN-1:0]    s_req_vld, s_req_rdy;
    logic [SLVN*AW-1:0] s_req_addr;
    logic [SLVN*DW-1:0] s_req_data;
    logic [SLVN-1:0]    s_rsp_vld, s_rsp_rdy;
    logic [SLVN*DW-1:0] s_rsp_data;

    modport master (
        output m_req_vld, m_req_addr, m_req_data, m_rsp_rdy, s_req_rdy, s_rsp_vld, s_rsp_data,
        input  m_req_rdy, m_rsp_vld, m_rsp_data, m_rsp_err, s_req_vld, s_req_addr, s_req_data, s_rsp_rdy
    );

    modport slave (
        input  m_req_vld, m_req_addr, m_req_data, m_rsp_rdy, s_req_rdy, s_rsp_vld, s_rsp_data,
        output m_req_rdy, m_rsp_vld, m_rsp_data, m_rsp_err, s_req_vld, s_req_addr, s_req_data, s_rsp_rdy
    );

endinterface

// File: rtl/axb_rr_arb.sv
// axb_rr_arb: N-wide round-robin arbiter, priority starts at ptr and wraps
// Ports: req (request vector), ptr (highest-priority index), gnt (one-hot grant), idx (grant index)
module axb_rr_arb
    import axb_xbar_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = selw(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    int c;

    // Walk from the farthest position back to ptr so the nearest requester is written last and wins
    always_comb begin
        gnt = '0;
        idx = '0;
        c   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            c = (int'(ptr) + i) % N;
            if (req[c]) begin
                gnt    = '0;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/axb_xbar_rr.sv
// axb_xbar_rr: MSTN x SLVN request/response crossbar with per-slave round-robin arbitration
// Ports: clk, rst_n (synchronous, active-low), bus (axb_xbar_rr_if.slave; m_* master side, s_* slave side)
// Routing: slave = addr[AW-1 -: SELW]; unmapped or MST_SLV_MAP-denied accesses get a local error
// response carrying DEF_RDATA. Optional: define AXB_XBAR_TIMEOUT_EN for a per-slave TMO_CYC timeout.
module axb_xbar_rr
    import axb_xbar_pkg::*;
#(
    parameter int                   MSTN        = 4,
    parameter int                   SLVN        = 8,
    parameter int                   AW          = 16,
    parameter int                   DW          = 8,
    parameter logic [MSTN*SLVN-1:0] MST_SLV_MAP = '1,
    parameter logic [DW-1:0]        DEF_RDATA   = DW'(DEF_RDATA_C)
`ifdef AXB_XBAR_TIMEOUT_EN
    , parameter int                 TMO_CYC     = TMO_CYC_C
`endif
) (
    input logic          clk,
    input logic          rst_n,
    axb_xbar_rr_if.slave bus
);
    localparam int SELW = selw(SLVN);
    localparam int IW   = selw(MSTN);

    logic [SELW-1:0] sel [MSTN];
    logic [MSTN-1:0] ill, free, busy, err_pend, rsp_vld, rsp_hs, gnt_or, tmo_m, req_rdy;
    logic [MSTN-1:0] cand [SLVN];
    logic [MSTN-1:0] gnt [SLVN];
    logic [IW-1:0]   gidx [SLVN];
    logic [AW-1:0]   gaddr [SLVN];
    logic [DW-1:0]   gdata [SLVN];
    slv_st_e         st [SLVN];
    logic [IW-1:0]   id [SLVN];
    logic [IW-1:0]   ptr [SLVN];
    logic [AW-1:0]   addr_q [SLVN];
    logic [DW-1:0]   data_q [SLVN];
    logic [SLVN-1:0] srdy, tmo_s;

    for (genvar m = 0; m < MSTN; m++) begin : g_dec
        localparam logic [SLVN-1:0] ROW = MST_SLV_MAP[m*SLVN +: SLVN];
        assign sel[m] = bus.m_req_addr[m*AW+AW-1 -: SELW];
        assign ill[m] = int'(sel[m]) >= SLVN || !ROW[sel[m]];
    end

    // Nothing is accepted while reset is held
    assign free    = bus.m_req_vld & ~busy & {MSTN{rst_n}};
    assign req_rdy = gnt_or | (free & ill);
    assign rsp_hs  = rsp_vld & bus.m_rsp_rdy;

    assign bus.m_req_rdy = req_rdy;
    assign bus.m_rsp_vld = rsp_vld;
    assign bus.m_rsp_err = err_pend;

    always_comb begin
        for (int s = 0; s < SLVN; s++)
            for (int m = 0; m < MSTN; m++)
                cand[s][m] = free[m] && !ill[m] && sel[m] == SELW'(s) && st[s] == IDLE;
    end

    for (genvar s = 0; s < SLVN; s++) begin : g_arb
        axb_rr_arb #(.N(MSTN), .IW(IW)) u_arb (
            .req(cand[s]),
            .ptr(ptr[s]),
            .gnt(gnt[s]),
            .idx(gidx[s])
        );
    end

    always_comb begin
        gnt_or = '0;
        for (int s = 0; s < SLVN; s++) begin
            gaddr[s] = '0;
            gdata[s] = '0;
            gnt_or   |= gnt[s];
            for (int m = 0; m < MSTN; m++)
                if (gnt[s][m]) begin
                    gaddr[s] = bus.m_req_addr[m*AW +: AW];
                    gdata[s] = bus.m_req_data[m*DW +: DW];
                end
        end
    end

    // A master has at most one outstanding request, so at most one source drives its response
    always_comb begin
        rsp_vld        = err_pend;
        tmo_m          = '0;
        bus.m_rsp_data = '0;
        for (int m = 0; m < MSTN; m++) begin
            if (err_pend[m]) bus.m_rsp_data[m*DW +: DW] = DEF_RDATA;
            for (int s = 0; s < SLVN; s++)
                if (id[s] == IW'(m)) begin
                    if (st[s] == RSP) begin
                        rsp_vld[m]                = rsp_vld[m] | bus.s_rsp_vld[s];
                        bus.m_rsp_data[m*DW +: DW] = bus.s_rsp_data[s*DW +: DW];
                    end
                    tmo_m[m] = tmo_m[m] | tmo_s[s];
                end
        end
    end

`ifdef AXB_XBAR_TIMEOUT_EN
    localparam int CW    = $clog2(TMO_CYC + 1);
    localparam bit DRAIN = 1'b1;
    logic [CW-1:0] cnt [SLVN];

    // Counter is held at zero in IDLE, so it starts from zero on REQ entry
    always_ff @(posedge clk)
        for (int s = 0; s < SLVN; s++)
            cnt[s] <= (!rst_n || st[s] == IDLE) ? '0 : cnt[s] + 1'b1;

    // A genuine response handshake in the same cycle takes precedence over the timeout
    always_comb
        for (int s = 0; s < SLVN; s++)
            tmo_s[s] = st[s] != IDLE && cnt[s] == CW'(TMO_CYC - 1) &&
                       !(st[s] == RSP && bus.s_rsp_vld[s] && srdy[s]);
`else
    localparam bit DRAIN = 1'b0;
    assign tmo_s = '0;
`endif

    // With the timeout, IDLE slaves drain stale responses
    always_comb begin
        for (int s = 0; s < SLVN; s++) begin
            srdy[s]                    = st[s] == RSP ? bus.m_rsp_rdy[id[s]] : DRAIN && st[s] == IDLE;
            bus.s_req_vld[s]           = st[s] == REQ;
            bus.s_req_addr[s*AW +: AW] = addr_q[s];
            bus.s_req_data[s*DW +: DW] = data_q[s];
        end
    end
    assign bus.s_rsp_rdy = srdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SLVN; s++) begin
                st[s]     <= IDLE;
                id[s]     <= '0;
                ptr[s]    <= '0;
                addr_q[s] <= '0;
                data_q[s] <= '0;
            end
            busy     <= '0;
            err_pend <= '0;
        end else begin
            for (int s = 0; s < SLVN; s++) begin
                if (tmo_s[s]) st[s] <= IDLE;
                else if (st[s] == IDLE && |gnt[s]) begin
                    st[s]     <= REQ;
                    id[s]     <= gidx[s];
                    ptr[s]    <= gidx[s] == IW'(MSTN - 1) ? '0 : gidx[s] + 1'b1;
                    addr_q[s] <= gaddr[s];
                    data_q[s] <= gdata[s];
                end
                else if (st[s] == REQ && bus.s_req_rdy[s]) st[s] <= RSP;
                else if (st[s] == RSP && bus.s_rsp_vld[s] && srdy[s]) st[s] <= IDLE;
            end
            busy     <= req_rdy | (busy & ~rsp_hs);
            err_pend <= (req_rdy & ill) | tmo_m | (err_pend & ~rsp_hs);
        end
    end

endmodule

// File: doc/axb_xbar_rr.md
Name: axb_xbar_rr

Overview:
- Parametrised MSTN-master x SLVN-slave request/response crossbar with per-slave round-robin arbitration.
- Address-decoded routing with a master-to-slave access map.
- Disallowed or unmapped accesses get a locally generated error response carrying a default pattern.
- Sits between bus masters and slave ports at the AXB top level; replaces the stubbed tie-offs with real routing.

Parameters:
- MSTN, 4, number of masters (2..8)
- SLVN, 8, number of slaves (2..16)
- AW, 16, address width; slave select = addr[AW-1 -: SELW], SELW = $clog2(SLVN)
- DW, 8, request/response data width
- MST_SLV_MAP, all ones, MSTN*SLVN bits; bit m*SLVN+s = master m may access slave s
- DEF_RDATA, 8'hAC (zero-extended to DW), data returned on error responses
- TMO_CYC, 256, timeout threshold in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- m_req_vld/m_req_rdy  in/out  MSTN  master request handshake
- m_req_addr  in  MSTN*AW  master request addresses
- m_req_data  in  MSTN*DW  master request data
- m_rsp_vld/m_rsp_rdy  out/in  MSTN  master response handshake
- m_rsp_data  out  MSTN*DW  master response data
- m_rsp_err  out  MSTN  error flag on the master response
- s_req_vld/s_req_rdy  out/in  SLVN  slave request handshake
- s_req_addr  out  SLVN*AW  slave request addresses
- s_req_data  out  SLVN*DW  slave request data
- s_rsp_vld/s_rsp_rdy  in/out  SLVN  slave response handshake
- s_rsp_data  in  SLVN*DW  slave response data

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values:
  - All vld/rdy outputs, data outputs and err outputs are 0.
  - RR pointers reset to 0; all master busy flags cleared; all slave FSMs go to IDLE.
- A reset mid-transaction abandons the transaction silently.
- Master busy flag:
  - Set when the master's request is accepted; cleared on the m_rsp handshake.
  - m_req_rdy[m] is never asserted while busy[m] is set, so each master has at most one outstanding request.
- Decode:
  - sel = addr[AW-1 -: SELW].
  - The request is illegal if sel >= SLVN or MST_SLV_MAP bit for (m, sel) is 0.
- Slave FSM, one per slave, states IDLE, REQ, RSP:
  - IDLE: candidates = masters with vld, not busy, legal, sel == s. RR grant starts at the pointer. Grant g gets m_req_rdy[g]=1 this cycle. Capture addr, data and id = g; set ptr = (g+1) mod MSTN; go to REQ.
  - REQ: s_req_vld=1 with the captured addr/data. On s_req_rdy, go to RSP. Latency from request accept to s_req_vld is 1 cycle.
  - RSP: m_rsp_vld[id] = s_rsp_vld; m_rsp_data[id] = s_rsp_data; m_rsp_err[id] = 0; s_rsp_rdy = m_rsp_rdy[id]. On the handshake, go to IDLE. Back-to-back requests are possible: a new grant can occur in the cycle after returning to IDLE.
  - s_rsp_rdy is 0 outside RSP.
- Error path, per master:
  - An illegal request is accepted in the same cycle (m_req_rdy=1) and sets busy.
  - From the next cycle: m_rsp_vld=1, m_rsp_err=1, m_rsp_data=DEF_RDATA, held until m_rsp_rdy.
  - Error acceptance does not involve any arbiter.
- Simultaneous events:
  - A master gets a single target per cycle, so there is no double grant.
  - Responses never collide at a master, because each master has one outstanding request.
  - m_rsp_vld or data changing while not accepted is a protocol violation by the slave; the crossbar passes it through unchanged.
- Slave-side request signals are stable while s_req_vld=1 and not ready.

Optional Feature:
- Macro: AXB_XBAR_TIMEOUT_EN.
- With the macro defined:
  - Each slave has a counter of width $clog2(TMO_CYC+1). It clears on entering REQ and counts in REQ and RSP.
  - On reaching TMO_CYC the slave FSM returns an error response to master id (err=1, DEF_RDATA, held until m_rsp_rdy), then goes to IDLE.
  - In IDLE, s_rsp_rdy=1 so a stale late response is drained and discarded.
- Without the macro: no counter, no timeout; a slave that never responds locks that slave indefinitely.

Decomposition:
- Package axb_xbar_pkg holds:
  - the slave FSM state enum (IDLE/REQ/RSP);
  - the default DEF_RDATA and TMO_CYC constants;
  - the SELW calculation function.
- Sub-module axb_rr_arb (MSTN-wide round-robin arbiter: req vector, ptr, one-hot grant, grant index) is instantiated once per slave.

Test Plan (defaults; sel = addr[15:13]):
- M0 request addr 16'h2004 data 8'h5A, slave 1 ready immediately, rsp 8'h33 -> s_req_vld[1] one cycle after accept with addr 2004/data 5A; m_rsp_data[0]=8'h33, err=0.
- M0..M3 request slave 5 simultaneously and continuously, 1-cycle slave responses -> grant order 0,1,2,3,0; each master is served once per 4 transactions.
- MST_SLV_MAP clears bit (2,6); M2 requests addr 16'hC000 -> accepted the same cycle; next cycle m_rsp_vld[2]=1, err=1, data 8'hAC; s_req_vld[6] never asserted.
- M1 to slave 3 and M2 to slave 7 concurrently -> both in flight in parallel with no cross-routing; M1 sends a second request before its response -> m_req_rdy[1] stays 0 until the rsp handshake.
- rst_n low for one cycle while slave 4 is in RSP -> next cycle all vld/rdy outputs are 0 and the pointers are 0; a new request to slave 4 goes to master 0 first.
- AXB_XBAR_TIMEOUT_EN, TMO_CYC=16, slave 0 silent -> err response with 8'hAC 16 cycles after REQ entry; a late s_rsp_vld[0] is drained with s_rsp_rdy[0]=1 and is not forwarded.
